// File: rtl/core_stream_checker.sv
// core_stream_checker
// -------------------
// Receive-side checker for the per-core greeble byte stream. It regenerates the
// expected byte sequence from the core seed using a bit-exact model of the leaf
// core's LFSR-plus-adder datapath and compares every accepted byte against it.
//
// Optional feature macro: CORE_CHECKER_MISR_EN
//   defined   -> 16-bit MISR over accepted bytes drives `signature`
//   undefined -> no MISR logic, `signature` tied to 16'h0000
//
// Ports
//   clk            in   1   clock, rising edge
//   rst            in   1   synchronous active-high reset
//   start          in   1   begin a run (honoured only in IDLE)
//   seed           in   8   core seed, captured on an honoured start
//   in_valid       in   1   input byte valid
//   in_ready       out  1   checker accepts a byte this cycle (RUN only)
//   in_data        in   8   received byte
//   busy           out  1   high in RUN
//   done           out  1   one-cycle end-of-run pulse
//   pass           out  1   last completed run had no mismatches
//   err_count      out  8   mismatches in current/last run
//   first_err_idx  out  8   index of first mismatch, 8'hFF if none
//   signature      out  16  MISR signature of accepted bytes
module core_stream_checker #(
    parameter int NUM_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  seed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [7:0]  first_err_idx,
    output logic [15:0] signature
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Expected byte of the leaf core for the current LFSR state (8-bit wrap).
    function automatic logic [7:0] exp_byte(input logic [15:0] st, input logic [7:0] sd);
        exp_byte = st[15:8] + st[7:0] + sd;
    endfunction

    // Leaf-core LFSR step; the seed LSB is folded into the feedback.
    function automatic logic [15:0] lfsr_next(input logic [15:0] st, input logic sd0);
        lfsr_next = {st[14:0], st[15] ^ st[13] ^ sd0};
    endfunction

    state_t      fsm_r;
    logic [7:0]  seed_q_r;
    logic [15:0] lfsr_r;
    logic [7:0]  idx_r;
    logic        in_ready_r;
    logic        busy_r;
    logic        done_r;
    logic        pass_r;
    logic [7:0]  err_count_r;
    logic [7:0]  first_err_idx_r;
    logic        accept_s;
    logic        mismatch_s;

    // Handshake and compare decode; in_ready_r is only ever high in RUN.
    always_comb begin
        accept_s   = in_valid & in_ready_r;
        mismatch_s = (in_data != exp_byte(lfsr_r, seed_q_r));
    end

    // Main control FSM together with the run counters and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r           <= ST_IDLE;
            seed_q_r        <= 8'h00;
            lfsr_r          <= 16'h0000;
            idx_r           <= 8'h00;
            in_ready_r      <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
            err_count_r     <= 8'h00;
            first_err_idx_r <= 8'hFF;
        end else begin
            done_r <= 1'b0;
            case (fsm_r)
                ST_IDLE: begin
                    if (start) begin
                        seed_q_r        <= seed;
                        lfsr_r          <= {seed, seed};
                        idx_r           <= 8'h00;
                        err_count_r     <= 8'h00;
                        first_err_idx_r <= 8'hFF;
                        pass_r          <= 1'b0;
                        in_ready_r      <= 1'b1;
                        busy_r          <= 1'b1;
                        fsm_r           <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        if (mismatch_s) begin
                            err_count_r <= err_count_r + 8'd1;
                            if (first_err_idx_r == 8'hFF) begin
                                first_err_idx_r <= idx_r;
                            end
                        end
                        lfsr_r <= lfsr_next(lfsr_r, seed_q_r[0]);
                        idx_r  <= idx_r + 8'd1;
                        // Drop ready on the final accept so the DONE cycle never accepts.
                        if (idx_r == LAST_IDX) begin
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            fsm_r      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                    pass_r <= (err_count_r == 8'd0);
                    fsm_r  <= ST_IDLE;
                end
                default: begin
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    fsm_r      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CORE_CHECKER_MISR_EN
    // One MISR step: shift with feedback taps 15/14/12/3, then fold in the byte.
    function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [7:0] d);
        misr_next = {sig[14:0], sig[15] ^ sig[14] ^ sig[12] ^ sig[3]} ^ {8'h00, d};
    endfunction

    logic [15:0] signature_r;

    // MISR over accepted bytes, cleared on reset and on an honoured start.
    always_ff @(posedge clk) begin
        if (rst) begin
            signature_r <= 16'h0000;
        end else if ((fsm_r == ST_IDLE) && start) begin
            signature_r <= 16'h0000;
        end else if (accept_s) begin
            signature_r <= misr_next(signature_r, in_data);
        end
    end

    assign signature = signature_r;
`else
    assign signature = 16'h0000;
`endif

    assign in_ready      = in_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_count_r;
    assign first_err_idx = first_err_idx_r;

endmodule

// File: doc/core_stream_checker.md
# core_stream_checker

Receive-side checker for the per-core greeble byte stream. It takes a seed and a stream of bytes over a valid/ready handshake, and regenerates the expected sequence with a bit-exact model of the leaf core's LFSR-plus-adder datapath. It compares each received byte against the expected one and reports the pass/fail result, the error count and the first failing index. It sits downstream of a core or cluster output tap and is used for on-die self-check of the generator array.

## Interface
Parameters:
- NUM_BYTES, 16: bytes checked per run; legal range 1..254.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- seed  in  8  core seed; captured on an honoured start.
- in_valid  in  1  input byte is valid.
- in_ready  out  1  checker accepts a byte this cycle.
- in_data  in  8  received byte.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse marking the end of a run.
- pass  out  1  last completed run had zero mismatches; held until the next honoured start.
- err_count  out  8  mismatches in the current or last run.
- first_err_idx  out  8  index of the first mismatch; 0xFF when there is none.
- signature  out  16  MISR signature of the accepted bytes.

## Operation
- **States:** IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE:**
  - in_ready = 0 and busy = 0.
  - start = 1 does the following: seed_q = seed, state = {seed, seed}, idx = 0, err_count = 0, first_err_idx = 0xFF, pass = 0, signature = 0. The FSM then moves to RUN.
- **RUN:**
  - in_ready = 1 and busy = 1.
  - A byte is accepted when in_valid & in_ready.
- **On each accept:**
  - expected = (state[15:8] + state[7:0] + seed_q) mod 256.
  - If in_data != expected, err_count increments. first_err_idx = idx if it is still 0xFF.
  - state <= {state[14:0], state[15] ^ state[13] ^ seed_q[0]}.
  - idx increments.
  - If this accept has idx == NUM_BYTES-1, the FSM moves to DONE.
- **No accept:** state, idx and counters hold.
- **DONE (one cycle):**
  - done = 1, and pass = (err_count == 0).
  - The FSM then moves to IDLE.
  - start presented in DONE is ignored.
- **start in RUN** is ignored; seed is not resampled.
- **Reset mid-run** aborts the run immediately and returns to IDLE with all outputs at reset values. No done pulse is produced.
- **Arithmetic widths:**
  - All additions are 8-bit and wrap.
  - err_count cannot overflow because NUM_BYTES ≤ 254.
  - idx is 8 bits.

## Timing
- Reset values: in_ready 0, busy 0, done 0, pass 0, err_count 0, first_err_idx 0xFF, signature 0. FSM is in IDLE.
- in_ready and busy are decoded from the registered FSM state only, with no combinational path from inputs. They rise the cycle after an honoured start.
- Throughput is one byte per cycle in RUN.
- The final accept is at edge N. done and the updated pass are visible after edge N+1, and in_ready is 0 in that cycle.
- err_count, first_err_idx and signature update on the edge that accepts the byte.
- err_count, first_err_idx and signature hold after DONE until the next honoured start.

## Configuration
- CORE_CHECKER_MISR_EN defined: signature is a 16-bit MISR, updated on each accept as follows.
  - signature <= {signature[14:0], signature[15]^signature[14]^signature[12]^signature[3]} ^ {8'h00, in_data}.
  - The MISR is cleared on an honoured start and on reset.
- CORE_CHECKER_MISR_EN undefined: the MISR is not synthesized and signature is tied to 16'h0000. All other behaviour is identical.

## Test plan
- **Zero seed:** rst, then start with seed 0x00 and stream 16 × 0x00 at full rate.
  - busy for exactly 16 cycles.
  - done pulse one cycle after the 16th accept.
  - pass 1, err_count 0, first_err_idx 0xFF, signature 0x0000.
- **Golden sequence:** seed 0x01, with expected bytes 0x03, 0x06, 0x0C, ….
  - Model states are 0x0101 → 0x0203 → 0x0407.
  - Feeding the model-correct bytes gives pass 1.
- **Single corruption:** seed 0x01 with byte 1 sent as 0x07 instead of 0x06.
  - err_count 1, first_err_idx 0x01, pass 0.
- **Backpressure and gaps:** seed 0x01 with in_valid toggled 1,0,0,1,….
  - Expected values advance only on accepts.
  - Result is identical to the full-rate run.
  - start pulsed during RUN is ignored (seed unchanged, idx unchanged).
- **Reset mid-run:** rst asserted after 5 accepts.
  - The next cycle is in IDLE with in_ready 0, err_count 0, first_err_idx 0xFF, and no done pulse.
  - A new start runs cleanly.
- **MISR (macro on/off):** NUM_BYTES=1, seed 0x00, byte 0x01.
  - With CORE_CHECKER_MISR_EN: signature 0x0001 and err_count 1.
  - Without the macro: signature 0x0000 and all other outputs are equal.
